// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding imem request
// at a time and hands each word to decode over valid/ready. Option: FETCH_DELAY_SLOT_EN.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_saved;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_valid;
`ifdef FETCH_DELAY_SLOT_EN
  logic              r_ds_pending;
`else
  logic              r_drop;
`endif

  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_pc_inc;

  // Low target bits are forced to zero so fetches stay word aligned.
  assign w_tgt    = redirect_target & ~ADDR_W'(3);
  assign w_pc_inc = r_pc + ADDR_W'(4);

`ifdef FETCH_DELAY_SLOT_EN
  assign imem_req = ~rst & (r_state == S_FETCH);
`else
  assign imem_req = ~rst & (r_state == S_FETCH) & ~redirect;
`endif
  assign imem_addr  = r_pc;
  assign inst_valid = r_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_saved   <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
      r_ds_pending <= 1'b0;
`else
      r_drop    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
`ifdef FETCH_DELAY_SLOT_EN
          r_state <= S_WAIT;
`else
          if (redirect) r_pc <= w_tgt;
          else          r_state <= S_WAIT;
`endif
        end
        S_WAIT: begin
`ifdef FETCH_DELAY_SLOT_EN
          if (imem_ack) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= r_pc;
            r_valid   <= 1'b1;
            r_state   <= S_HOLD;
          end
`else
          if (imem_ack) begin
            if (r_drop || redirect) begin
              // Wrong-path response: discard and restart at the newest target.
              r_pc    <= redirect ? w_tgt : r_saved;
              r_drop  <= 1'b0;
              r_state <= S_FETCH;
            end else begin
              r_inst    <= imem_rdata;
              r_inst_pc <= r_pc;
              r_valid   <= 1'b1;
              r_state   <= S_HOLD;
            end
          end else if (redirect) begin
            r_drop  <= 1'b1;
            r_saved <= w_tgt;
          end
`endif
        end
        S_HOLD: begin
`ifdef FETCH_DELAY_SLOT_EN
          if (inst_ready) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
            if (r_ds_pending) begin
              r_pc         <= r_saved;
              r_ds_pending <= 1'b0;
            end else begin
              r_pc <= w_pc_inc;
              if (redirect) begin
                r_saved      <= w_tgt;
                r_ds_pending <= 1'b1;
              end
            end
          end
`else
          if (redirect) begin
            r_pc    <= w_tgt;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end else if (inst_ready) begin
            r_pc    <= w_pc_inc;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
`endif
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected fetch addresses
// and delivered words; a negedge monitor pops and compares them.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_target;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int prev_hs = -1;
  int ack_delay = 1;
  bit mon_en = 1'b1;
  bit period_on = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_ipc_q[$];

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect), .redirect_target(redirect_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #20000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h2108_0001;
    if (a == 32'h0000_0010) return 32'h0800_0010;
    return {a[15:0], 16'hBEEF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_inst_q.push_back(d);
    exp_ipc_q.push_back(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_req: got no imem_req expected imem_req within 50 cycles");
    end
  endtask

  task automatic hold_redirect(input logic [31:0] tgt);
    wait_req();
    step();
    step();
    redirect        = 1'b1;
    redirect_target = tgt;
    step();
    redirect        = 1'b0;
  endtask

  // Memory model: acks ack_delay cycles after each sampled request.
  initial begin
    logic [31:0] a;
    int d;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        a = imem_addr;
        d = ack_delay;
        repeat (d) @(posedge clk);
        #1;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(a);
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (imem_req) begin
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
          end else begin
            e = exp_addr_q.pop_front();
            chk("imem_addr", imem_addr, e);
          end
        end
        if (inst_valid && inst_ready) begin
          if (exp_inst_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_inst: got %h at pc %h expected none", inst, inst_pc);
          end else begin
            e = exp_inst_q.pop_front();
            chk("inst", inst, e);
            e = exp_ipc_q.pop_front();
            chk("inst_pc", inst_pc, e);
          end
          if (period_on && prev_hs >= 0) chk("hs_period", 32'(cyc - prev_hs), 32'd3);
          prev_hs = cyc;
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    inst_ready      = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Back-to-back fetches with immediate ack and ready.
    push_fetch(32'h0000_0000, 32'h0000_BEEF);
    push_fetch(32'h0000_0004, 32'h0004_BEEF);
    push_fetch(32'h0000_0008, 32'h0008_BEEF);
    push_fetch(32'h0000_000C, 32'h2108_0001);
    period_on = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) wait_req();
    period_on = 1'b0;

    // Decode stalls for several cycles on the word at 0xC.
    step();
    inst_ready = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (inst_valid) got = 1'b1;
      end
      chk("hold_valid_seen", 32'(got), 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_inst", inst, 32'h2108_0001);
      chk("hold_inst_pc", inst_pc, 32'h0000_000C);
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_no_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    step();
    inst_ready = 1'b1;

`ifdef FETCH_DELAY_SLOT_EN
    push_fetch(32'h0000_0010, 32'h0800_0010);
    push_fetch(32'h0000_0014, 32'h0014_BEEF);
    push_fetch(32'h0000_0018, 32'h0018_BEEF);
    push_fetch(32'h0000_0020, 32'h0020_BEEF);
    push_fetch(32'h0000_0024, 32'h0024_BEEF);
    push_fetch(32'h0000_0100, 32'h0100_BEEF);
    push_fetch(32'h0000_0104, 32'h0104_BEEF);
    push_fetch(32'hFFFF_FFFC, 32'hFFFC_BEEF);
`else
    push_req(32'h0000_0010);
    push_fetch(32'h0000_0040, 32'h0040_BEEF);
    push_fetch(32'h0000_0020, 32'h0020_BEEF);
    push_fetch(32'h0000_0100, 32'h0100_BEEF);
    push_fetch(32'hFFFF_FFFC, 32'hFFFC_BEEF);
`endif
    push_req(32'h0000_0000);

    // Redirect while waiting; the slow response for 0x10 is wrong-path.
    ack_delay = 3;
    wait_req();
    step();
    redirect        = 1'b1;
    redirect_target = 32'h0000_0043;
    step();
    redirect  = 1'b0;
    ack_delay = 1;

    hold_redirect(32'h0000_0020);
`ifdef FETCH_DELAY_SLOT_EN
    wait_req();
`endif
    hold_redirect(32'h0000_0100);
`ifdef FETCH_DELAY_SLOT_EN
    wait_req();
`endif
    hold_redirect(32'hFFFF_FFFC);
`ifdef FETCH_DELAY_SLOT_EN
    wait_req();
`endif
    wait_req();
    step();
    ack_delay = 3;

    // PC wrapped to 0; reset arrives while that fetch is outstanding.
    wait_req();
    step();
    rst = 1'b1;
    #1;
    chk("wait_rst_req", 32'(imem_req), 32'd0);
    chk("wait_rst_valid", 32'(inst_valid), 32'd0);
    chk("wait_rst_inst", inst, 32'h0);
    chk("wait_rst_addr", imem_addr, 32'h0);
    ack_delay = 1;
    repeat (4) step();
    push_fetch(32'h0000_0000, 32'h0000_BEEF);
    rst = 1'b0;

    for (int i = 0; i < 30 && (exp_addr_q.size() != 0 || exp_inst_q.size() != 0); i++)
      @(posedge clk);
    mon_en = 1'b0;
    chk("req_queue_left", 32'(exp_addr_q.size()), 32'd0);
    chk("inst_queue_left", 32'(exp_inst_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
